cosine: RTL and testbench

Sequential ALU function unit that returns the cosine of an integer angle in degrees as a BF16 value. It complements the slope-to-angle inverse-trig units: the input is an integer angle, and the output is a BF16 value. Internally the block does range reduction, quadrant folding, a 16-iteration CORDIC and a BF16 normaliser. It sits beside the other ALU units and shares their start/done handshake.

---
 rtl/cosine.sv | 181 ++++++++++++++++++
 tb/tb_cosine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cosine.sv
// Sequential cosine unit: integer angle in degrees in, BF16 cosine out.
// Range reduction, quadrant fold, 16-step CORDIC in degrees, then BF16 normalise.
module cosine #(
    parameter int ITER        = 16,
    parameter int INPUTOUTBIT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic signed [INPUTOUTBIT-1:0] a,
    output logic        [INPUTOUTBIT-1:0] result,
    output logic                          error,
    output logic                          done
);

    typedef enum logic [2:0] {IDLE, REDUCE, FOLD, CORDIC, NORM, DONE_ST} state_t;

    localparam logic signed [18:0]             K_INIT = 19'sd39797;
    localparam logic signed [INPUTOUTBIT-1:0]  A_MAX  = INPUTOUTBIT'(999);

    state_t             state, next_state;
    logic        [15:0] r;
    logic               neg;
    logic signed [18:0] x, y;
    logic signed [23:0] z;
    logic        [3:0]  iter;

    logic               in_range;
    logic        [15:0] abs_a;
    logic        [15:0] fold_r;
    logic               fold_neg;
    logic signed [18:0] x_sh, y_sh;
    logic        [3:0]  lead;
    logic        [7:0]  frac;
    logic        [7:0]  mant_sum;
    logic        [7:0]  bf_exp;
    logic        [15:0] norm_word;

    // atan(2^-i) in degrees, Q7.16, rounded to nearest
    function automatic logic signed [23:0] atan_deg(input logic [3:0] i);
        case (i)
            4'd0:    atan_deg = 24'sd2949120;
            4'd1:    atan_deg = 24'sd1740967;
            4'd2:    atan_deg = 24'sd919879;
            4'd3:    atan_deg = 24'sd466945;
            4'd4:    atan_deg = 24'sd234379;
            4'd5:    atan_deg = 24'sd117304;
            4'd6:    atan_deg = 24'sd58666;
            4'd7:    atan_deg = 24'sd29335;
            4'd8:    atan_deg = 24'sd14668;
            4'd9:    atan_deg = 24'sd7334;
            4'd10:   atan_deg = 24'sd3667;
            4'd11:   atan_deg = 24'sd1833;
            4'd12:   atan_deg = 24'sd917;
            4'd13:   atan_deg = 24'sd458;
            4'd14:   atan_deg = 24'sd229;
            default: atan_deg = 24'sd115;
        endcase
    endfunction

    always_comb begin
        in_range = (a <= A_MAX) && (a >= -A_MAX);
        abs_a    = 16'(a[INPUTOUTBIT-1] ? -a : a);
        x_sh     = x >>> iter;
        y_sh     = y >>> iter;
    end

    // Fold [0,359] onto [0,90]; the second and third quadrants flip the sign
    always_comb begin
        fold_r   = r;
        fold_neg = 1'b0;
        if (r > 16'd270) begin
            fold_r = 16'd360 - r;
        end else if (r > 16'd90) begin
            fold_neg = 1'b1;
            fold_r   = (r >= 16'd180) ? r - 16'd180 : 16'd180 - r;
        end
    end

    always_comb begin
        lead = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (x[k]) lead = 4'(k);
        end
        frac      = 8'((x[15:0] << (4'd15 - lead)) >> 7);
        mant_sum  = {1'b0, frac[7:1]} + {7'b0, frac[0]};
        bf_exp    = 8'd111 + {4'b0, lead} + {7'b0, mant_sum[7]};
        norm_word = {neg, bf_exp, mant_sum[6:0]};
        if (x >= 19'sd65536) begin
            norm_word = {neg, 8'd127, 7'd0};
        end else if (x <= 19'sd0) begin
            norm_word = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = in_range ? REDUCE : DONE_ST;
            REDUCE:  if (r < 16'd360) next_state = FOLD;
            FOLD:    next_state = (fold_r == 16'd0 || fold_r == 16'd90) ? DONE_ST : CORDIC;
            CORDIC:  if (iter == 4'(ITER - 1)) next_state = NORM;
            NORM:    next_state = DONE_ST;
            DONE_ST: if (!start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r      <= '0;
            neg    <= 1'b0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            iter   <= '0;
            result <= '0;
            error  <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (start) begin
                        if (!in_range) begin
                            result <= 16'hFFC0;
                            error  <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            r <= abs_a;
                        end
                    end
                end
                REDUCE: begin
                    if (r >= 16'd360) r <= r - 16'd360;
                end
                FOLD: begin
                    r   <= fold_r;
                    neg <= fold_neg;
                    if (fold_r == 16'd0) begin
                        result <= fold_neg ? 16'hBF80 : 16'h3F80;
                        done   <= 1'b1;
                    end else if (fold_r == 16'd90) begin
                        result <= 16'h0000;
                        done   <= 1'b1;
                    end else begin
                        x    <= K_INIT;
                        y    <= '0;
                        z    <= {fold_r[7:0], 16'h0000};
                        iter <= '0;
                    end
                end
                CORDIC: begin
                    if (!z[23]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_deg(iter);
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_deg(iter);
                    end
                    iter <= iter + 4'd1;
                end
                NORM: begin
                    result <= norm_word;
                    done   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cosine.sv
// Bench for cosine: directed cases, a full angle sweep and random angles,
// checked against a real-arithmetic cosine model rounded to BF16.
module tb_cosine;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] a;
    logic        [15:0] result;
    logic               error;
    logic               done;

    int checks   = 0;
    int failures = 0;

    cosine #(.ITER(16), .INPUTOUTBIT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a),
        .result(result), .error(error), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] to_bf16(input real v);
        real  m;
        int   e;
        int   q;
        logic s;
        s = (v < 0.0);
        m = s ? -v : v;
        if (m < 1.0e-30) return 16'h0000;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        q = int'(m * 128.0);
        if (q >= 256) begin q = 128; e++; end
        return {s, 8'(e + 127), 7'(q - 128)};
    endfunction

    function automatic int exp_latency(input int ang);
        int m;
        m = (ang < 0) ? -ang : ang;
        if (m > 999) return 0;
        if (m % 90 == 0) return m / 360 + 2;
        return m / 360 + 19;
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        int  diff;
        logic ok;
        diff = int'(obs[14:0]) - int'(exp[14:0]);
        ok   = (obs[15] === exp[15]) && (diff <= 1) && (diff >= -1) && !$isunknown(obs);
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h within 1 ulp", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int ang, output int k);
        @(negedge clk);
        a     = 16'(ang);
        start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic check_op(input string tag, input int ang, input int k);
        int m;
        m = (ang < 0) ? -ang : ang;
        check_output({tag, "_lat"}, 16'(k), 16'(exp_latency(ang)));
        check_output({tag, "_err"}, {15'b0, error}, {15'b0, (m > 999)});
        if (m > 999)
            check_output({tag, "_res"}, result, 16'hFFC0);
        else if (m % 360 == 0)
            check_output({tag, "_res"}, result, 16'h3F80);
        else if (m % 360 == 180)
            check_output({tag, "_res"}, result, 16'hBF80);
        else if (m % 90 == 0)
            check_output({tag, "_res"}, result, 16'h0000);
        else
            check_near({tag, "_res"}, result, to_bf16($cos(real'(m) * 3.14159265358979323846 / 180.0)));
    endtask

    task automatic drop_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output({tag, "_clr"}, {15'b0, done}, 16'h0000);
    endtask

    typedef struct { int ang; logic [15:0] bits; } dir_t;
    dir_t dir_tab[10] = '{
        '{60, 16'h3F00}, '{0, 16'h3F80}, '{-180, 16'hBF80}, '{450, 16'h0000},
        '{270, 16'h0000}, '{45, 16'h3F35}, '{120, 16'hBF00}, '{-1, 16'h3F80},
        '{1000, 16'hFFC0}, '{-1000, 16'hFFC0}
    };

    initial begin
        int k;
        int seen;
        int ang;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_result", result, 16'h0000);
        check_output("rst_done", {15'b0, done}, 16'h0000);
        check_output("rst_error", {15'b0, error}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // a=60 with start held: done must persist while start stays high
        apply_stimulus(60, k);
        check_op("a60", 60, k);
        repeat (3) begin @(posedge clk); #1; end
        check_output("a60_hold_done", {15'b0, done}, 16'h0001);
        check_output("a60_hold_res", result, 16'h3F00);
        drop_start("a60");

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(dir_tab[i].ang, k);
            check_op("dir", dir_tab[i].ang, k);
            check_output("dir_exact", result, dir_tab[i].bits);
            drop_start("dir");
        end

        // Start and angle changes while busy must not disturb the latched angle
        @(negedge clk);
        a     = 16'd30;
        start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 6)  begin start = 1'b0; a = 16'd200; end
            if (k == 8)  start = 1'b1;
            if (k == 10) a = -16'sd77;
        end
        check_op("busy", 30, k);
        drop_start("busy");

        // Reset in the middle of CORDIC aborts with no done
        @(negedge clk);
        a     = 16'd30;
        start = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check_output("midrst_result", result, 16'h0000);
        check_output("midrst_done", {15'b0, done}, 16'h0000);
        check_output("midrst_error", {15'b0, error}, 16'h0000);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check_output("midrst_nodone", 16'(seen), 16'h0000);

        for (int s = -999; s <= 999; s++) begin
            apply_stimulus(s, k);
            check_op("sweep", s, k);
            drop_start("sweep");
        end

        for (int i = 0; i < 150; i++) begin
            ang = int'($urandom_range(2400)) - 1200;
            apply_stimulus(ang, k);
            check_op("rand", ang, k);
            drop_start("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
